// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO port arbiter: shares the memory pins between instruction-cache word
// fetches and load/store-buffer accesses, sequencing one byte per cycle.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    input  logic        ic_abort,
    output logic        ic_done,
    output logic [31:0] ic_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic        owner_ls_q, owner_ls_d;
    logic        last_ls_q, last_ls_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  iss_q, iss_d;
    logic [2:0]  cap_q, cap_d;

    logic [31:0] cur_addr;
    logic        stall;
    logic        ic_ok;
    logic        grant_ls;
    logic        grant_ic;

    assign cur_addr = addr_q + {29'd0, iss_q};
    assign stall    = (cur_addr >= IO_BASE) && io_buffer_full;

    assign mem_a    = cur_addr;
    assign mem_dout = wdata_q[{iss_q[1:0], 3'b000} +: 8];
    assign mem_wr   = rdy && (state_q == StWrite) && (iss_q < len_q) && !stall;
    assign ic_done  = rdy && (state_q == StDone) && !owner_ls_q && !ic_abort;
    assign ls_done  = rdy && (state_q == StDone) && owner_ls_q;
    assign ic_data  = data_q;
    assign ls_rdata = data_q;

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        last_ls_d  = last_ls_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        len_d      = len_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        ic_ok      = ic_req && !ic_abort;
        grant_ls   = 1'b0;
        grant_ic   = 1'b0;

        if (rdy) begin
            unique case (state_q)
                StIdle: begin
                    // On contention, LS wins unless it won the previous grant.
                    grant_ls = ls_req && !(ic_ok && last_ls_q);
                    grant_ic = ic_ok && !grant_ls;
                    if (grant_ls || grant_ic) begin
                        owner_ls_d = grant_ls;
                        last_ls_d  = grant_ls;
                        addr_d     = grant_ls ? ls_addr : ic_addr;
                        wdata_d    = ls_wdata;
                        data_d     = 32'd0;
                        iss_d      = 3'd0;
                        cap_d      = 3'd0;
                        if (!grant_ls || ls_size[1]) begin
                            len_d = 3'd4;
                        end else if (ls_size[0]) begin
                            len_d = 3'd2;
                        end else begin
                            len_d = 3'd1;
                        end
                        state_d = (grant_ls && ls_wr) ? StWrite : StRead;
                    end
                end
                StRead: begin
                    // mem_din holds the byte issued last cycle whenever cap trails iss.
                    if (cap_q < iss_q) begin
                        data_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                        cap_d = cap_q + 3'd1;
                        if (cap_d == len_q) begin
                            state_d = StDone;
                        end
                    end
                    if (iss_q < len_q) begin
                        iss_d = iss_q + 3'd1;
                    end
                end
                StWrite: begin
                    if ((iss_q < len_q) && !stall) begin
                        iss_d = iss_q + 3'd1;
                        if (iss_d == len_q) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end else if (state_q == StRead) begin
            // The byte in flight during a pause is lost; re-issue from the first uncaptured.
            iss_d = cap_q;
        end

        if (ic_abort && !owner_ls_q && (state_q == StRead)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            len_q      <= 3'd0;
            iss_q      <= 3'd0;
            cap_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            last_ls_q  <= last_ls_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            len_q      <= len_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole master of the byte-wide RAM/IO port. Shares it between the instruction cache (32-bit fetches) and the load/store buffer (1/2/4-byte loads and stores).
- Sequences multi-byte transfers one byte per cycle.
- Throttles IO stores on io_buffer_full.
- Sits between the core's cache/LSB and the top-level memory pins.

Parameters:
- IO_BASE, 32'h00030000, addresses >= IO_BASE are IO space.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = pause
- mem_din  in  8  RAM/IO read byte
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  UART buffer full
- ic_req  in  1  fetch request, held until ic_done or ic_abort
- ic_addr  in  32  fetch address, stable while ic_req
- ic_abort  in  1  drop any IC request or transfer
- ic_done  out  1  one-cycle fetch-complete pulse
- ic_data  out  32  fetched word, little-endian, valid with ic_done
- ls_req  in  1  load/store request, held until ls_done
- ls_wr  in  1  1 = store
- ls_addr  in  32  byte address
- ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ls_wdata  in  32  store data; bytes sent LSB first
- ls_done  out  1  one-cycle completion pulse
- ls_rdata  out  32  load data, zero-extended, valid with ls_done

Behaviour:
- Reset: state IDLE. mem_a, mem_dout, mem_wr, ic_done, ic_data, ls_done, ls_rdata and last_grant all cleared to 0.
- States: IDLE, READ, WRITE, DONE.
  - N = 4 for IC; N = 1, 2 or 4 for LS.
  - Two counters: issue index and capture index, each 0..N.
- RAM timing: the byte at the address held on mem_a in cycle k appears on mem_din in cycle k+1.
- Arbitration in IDLE:
  - If only one requester is active, it wins.
  - If both are active, LS wins unless last_grant = LS, in which case IC wins.
  - last_grant updates on each grant, so contention alternates between requesters.
  - The grant is captured at the cycle-0 edge.
  - A granted transfer is never preempted by the other requester.
- READ (IC fetch or LS load), granted at the end of cycle 0:
  - mem_a = A+i in cycle 1+i.
  - Byte i is captured at the end of cycle 2+i into bits [8i+7:8i].
  - done = 1 in cycle N+2; word fetch done in cycle 6.
- WRITE:
  - mem_wr = 1, mem_a = A+i, mem_dout = wdata[8i+7:8i] in cycle 1+i.
  - ls_done = 1 in cycle N+1.
  - mem_wr returns to 0 in the cycle after the last byte.
- IO store stall: if the next store byte's address >= IO_BASE and io_buffer_full = 1 in the issuing cycle:
  - That cycle has mem_wr = 0, and the byte is not counted.
  - Retry every cycle until io_buffer_full = 0.
- IO loads are not stalled.
- DONE: lasts exactly one cycle.
  - The done pulse is high in this cycle.
  - Requests are ignored in this cycle, so a requester dropping req on done is never re-served.
  - Next state is IDLE; the earliest next grant is decided in the cycle after DONE.
- ic_abort:
  - When high in any cycle, an IC grant or IC READ returns to IDLE next edge.
  - No ic_done is produced, mem_wr = 0, and IC data is discarded.
  - An LS transfer in progress is unaffected.
  - ic_abort together with ic_req in IDLE: no grant to IC.
- rdy = 0:
  - All state, counters and data registers hold.
  - mem_wr is forced to 0.
  - Done outputs are held low; a pending pulse is delivered after resume.
- Resume after rdy = 0:
  - READ sets issue index = capture index and re-issues from the first uncaptured byte, because the in-flight byte is lost.
  - WRITE continues from the first unwritten byte.
- rst mid-transfer: abandon immediately and return to reset values. No done pulse.
- Address arithmetic: A+i is a 32-bit add with natural wrap at 2^32.

Test Plan:
- Word fetch: ic_req, ic_addr = 0x100, RAM[0x100..0x103] = 13 05 00 00 -> mem_a 0x100..0x103 in cycles 1-4; ic_done = 1 in cycle 6 only with ic_data = 0x00000513; mem_wr = 0 throughout.
- Store/load: LS word store 0xDEADBEEF to 0x200 -> mem_dout EF, BE, AD, DE in cycles 1-4 with mem_wr = 1; ls_done in cycle 5. Then half load at 0x202 -> ls_rdata = 0x0000DEAD.
- Contention: ic_req and ls_req both held from reset, LS word load -> LS served first, then IC, then LS, alternating. No done pulse collides with a grant; no request starves.
- IO stall: byte store 0x41 to 0x30000 with io_buffer_full = 1 for 5 cycles -> mem_wr = 0 for those cycles; write issued in the first cycle io_buffer_full = 0; ls_done the next cycle.
- Abort: ic_abort pulsed in cycle 3 of a fetch -> no ic_done; a pending ls_req is granted from IDLE afterwards; ls_rdata is correct.
- rdy drop: rdy = 0 in cycles 3-5 of a word load -> mem_wr stays 0; after resume, bytes are re-issued from the first uncaptured one; final ls_rdata equals the memory word.
